// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : Byte RAM with memory-mapped UART TX/RX FIFOs, cycle counter and
//            halt port. Optional RX FIFO is enabled by defining MEM_IO_RX_EN.
// Revision : 1.0
// ============================================================================
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halt
);

    localparam int RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG;

    localparam logic [TX_DEPTH_LOG:0]   TX_ALMOST  = (TX_DEPTH_LOG + 1)'(TX_DEPTH - 2);
    localparam logic [TX_DEPTH_LOG:0]   TX_CNT_ONE = (TX_DEPTH_LOG + 1)'(1);
    localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE = TX_DEPTH_LOG'(1);

    localparam logic [17:0] IO_UART    = 18'h30000;
    localparam logic [17:0] IO_CNT_B0  = 18'h30004;
    localparam logic [17:0] IO_CNT_B1  = 18'h30005;
    localparam logic [17:0] IO_CNT_B2  = 18'h30006;
    localparam logic [17:0] IO_CNT_B3  = 18'h30007;

    // ------------------------------------------------------------------
    // Address decode and access qualifiers
    // ------------------------------------------------------------------
    logic [17:0]           io_addr;
    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  halt_req;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_addr;

    assign io_addr     = mem_a[17:0];
    assign is_io       = (mem_a[17:16] == 2'b11);
    assign ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign unused_addr = ^mem_a[31:18];

    // Writes are locked out once the halt command has been accepted.
    assign wr_en = rdy_in & mem_wr & ~halt & ~halt_req;
    assign rd_en = rdy_in & ~mem_wr;

    // ------------------------------------------------------------------
    // Byte RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] ram [RAM_WORDS];

    always_ff @(posedge clk_in) begin
        if (wr_en && !is_io) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]              tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] tx_wptr;
    logic [TX_DEPTH_LOG-1:0] tx_rptr;
    logic [TX_DEPTH_LOG:0]   tx_count;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    tx_push;
    logic                    tx_pop;
    logic                    char_wr;
    logic                    halt_cmd;
    logic                    halt_push;
    logic [7:0]              tx_wdata;

    assign tx_full  = tx_count[TX_DEPTH_LOG];
    assign tx_empty = (tx_count == '0);

    assign char_wr   = wr_en & is_io & (io_addr == IO_UART) & (mem_dout != 8'h00);
    assign halt_cmd  = wr_en & is_io & (io_addr == IO_CNT_B0);
    // The terminating 0x00 must not be lost, so it waits for a free slot.
    assign halt_push = rdy_in & (halt_cmd | halt_req) & ~tx_full;
    assign tx_push   = halt_push | (char_wr & ~tx_full);
    assign tx_wdata  = halt_push ? 8'h00 : mem_dout;
    assign tx_pop    = ~tx_empty & tx_ready;

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= tx_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + TX_PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CNT_ONE;
                2'b01:   tx_count <= tx_count - TX_CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    assign tx_valid       = ~tx_empty;
    assign tx_data        = tx_mem[tx_rptr];
    assign io_buffer_full = (tx_count >= TX_ALMOST);

    // ------------------------------------------------------------------
    // Halt control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            halt     <= 1'b0;
            halt_req <= 1'b0;
        end else if (halt_push) begin
            halt     <= 1'b1;
            halt_req <= 1'b0;
        end else if (halt_cmd) begin
            halt_req <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter, frozen by halt
    // ------------------------------------------------------------------
    logic [31:0] counter;
    logic [31:0] shadow;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            counter <= '0;
        end else if (!halt) begin
            counter <= counter + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [7:0] rx_head;
    logic       rx_empty;
    logic       uart_rd;

`ifdef MEM_IO_RX_EN
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [RX_DEPTH_LOG:0]   RX_CNT_ONE = (RX_DEPTH_LOG + 1)'(1);
    localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE = RX_DEPTH_LOG'(1);

    logic [7:0]              rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG-1:0] rx_wptr;
    logic [RX_DEPTH_LOG-1:0] rx_rptr;
    logic [RX_DEPTH_LOG:0]   rx_count;
    logic                    rx_full;
    logic                    rx_push;
    logic                    rx_pop;

    assign rx_full  = rx_count[RX_DEPTH_LOG];
    assign rx_empty = (rx_count == '0);
    // Held low while reset is asserted so no byte is handshaked into a cleared FIFO.
    assign rx_ready = rst_in & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_en & uart_rd & ~rx_empty;
    assign rx_head  = rx_mem[rx_rptr];

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + RX_PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CNT_ONE;
                2'b01:   rx_count <= rx_count - RX_CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic unused_rx;

    assign rx_ready  = 1'b0;
    assign rx_empty  = 1'b1;
    assign rx_head   = 8'h00;
    assign unused_rx = ^{rx_valid, rx_data, uart_rd, RX_DEPTH_LOG[0]};
`endif

    // ------------------------------------------------------------------
    // Read data selection and registered read port
    // ------------------------------------------------------------------
    logic [7:0] rd_byte;
    logic       snap;

    always_comb begin
        rd_byte = 8'h00;
        snap    = 1'b0;
        uart_rd = 1'b0;
        if (!is_io) begin
            rd_byte = ram[ram_idx];
        end else begin
            case (io_addr)
                IO_UART: begin
                    uart_rd = 1'b1;
                    rd_byte = rx_empty ? 8'h00 : rx_head;
                end
                IO_CNT_B0: begin
                    // Byte 0 comes live from the counter; bytes 1-3 from the snapshot.
                    snap    = 1'b1;
                    rd_byte = counter[7:0];
                end
                IO_CNT_B1: rd_byte = shadow[15:8];
                IO_CNT_B2: rd_byte = shadow[23:16];
                IO_CNT_B3: rd_byte = shadow[31:24];
                default:   rd_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din <= 8'h00;
            shadow  <= '0;
        end else if (rd_en) begin
            mem_din <= rd_byte;
            if (snap) begin
                shadow <= counter;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Brief    : Self-checking bench for mem_io_responder (vector table plus
//            read/TX scoreboards and multi-cycle sequences).
// Revision : 1.0
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in   = 1'b0;
    logic        rst_in   = 1'b1;
    logic        rdy_in   = 1'b1;
    logic [31:0] mem_a    = '0;
    logic        mem_wr   = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic        tx_ready = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        rx_ready;
    logic        halt;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .halt           (halt)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle count: edges seen since reset release.
    logic [31:0] cyc;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cyc <= '0;
        else         cyc <= cyc + 32'd1;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] expq[$];
    logic [7:0] txq[$];

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One bus cycle: drive, observe TX handshake, clock, then compare read data.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [7:0] d, input logic chk, input logic [7:0] ex,
                        input string tag);
        logic [7:0] want;
        rdy_in   = r;
        mem_wr   = w;
        mem_a    = a;
        mem_dout = d;
        if (chk) expq.push_back(ex);
        if (tx_valid && tx_ready) begin
            if (txq.size() == 0) check("tx_extra", 32'd1, 32'd0);
            else                 check("tx_data", tx_data, txq.pop_front());
        end
        @(posedge clk_in);
        #1;
        if (chk) begin
            want = expq.pop_front();
            check(tag, mem_din, want);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    task automatic uart_wr(input logic [7:0] d);
        if (d != 8'h00 && txq.size() < 8) txq.push_back(d);
        step(1'b1, 1'b1, 32'h30000, d, 1'b0, 8'h00, "uart_wr");
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk_in);
        #1;
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_tx_valid", tx_valid, 32'h0);
        check("rst_buf_full", io_buffer_full, 32'h0);
        check("rst_halt", halt, 32'h0);
        check("rst_rx_ready", rx_ready, 32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        txq.delete();
        expq.delete();
    endtask

    initial begin
        logic [31:0] want;
        logic [31:0] halt_at;

        vt[0]  = '{1'b1, 1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
        vt[2]  = '{1'b1, 1'b1, 32'h0000_0020, 8'h11, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 1'b1, 32'h0001_FFFF, 8'h7E, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h7E};
        vt[5]  = '{1'b1, 1'b1, 32'h0002_0044, 8'hC3, 1'b0, 8'h00};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_0044, 8'h00, 1'b1, 8'hC3};
        vt[7]  = '{1'b1, 1'b1, 32'hFFFC_0050, 8'h3C, 1'b0, 8'h00};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_0050, 8'h00, 1'b1, 8'h3C};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0020, 8'h00, 1'b1, 8'h11};
        vt[10] = '{1'b0, 1'b1, 32'h0000_0020, 8'h99, 1'b1, 8'h11};
        vt[11] = '{1'b0, 1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'h11};
        vt[12] = '{1'b1, 1'b0, 32'h0000_0020, 8'h00, 1'b1, 8'h11};
        vt[13] = '{1'b1, 1'b1, 32'h0003_0010, 8'h77, 1'b0, 8'h00};
        vt[14] = '{1'b1, 1'b0, 32'h0003_0010, 8'h00, 1'b1, 8'h00};
        vt[15] = '{1'b1, 1'b0, 32'h0003_FFFF, 8'h00, 1'b1, 8'h00};
        vt[16] = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00};

        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(vt[i].rdy, vt[i].wr, vt[i].a, vt[i].d, vt[i].chk, vt[i].exp,
                 $sformatf("vec%0d", i));
        end
        check("io_wr_no_tx", tx_valid, 32'h0);

        // Zero byte to the UART port is filtered out.
        uart_wr(8'h00);
        check("zero_no_tx", tx_valid, 32'h0);
        check("zero_buf_full", io_buffer_full, 32'h0);

        // Counter snapshot after ~100 cycles, bytes read on consecutive cycles.
        do_reset();
        idle(100);
        want = cyc;
        step(1'b1, 1'b0, 32'h30004, 8'h00, 1'b1, want[7:0],   "cnt_b0");
        step(1'b1, 1'b0, 32'h30005, 8'h00, 1'b1, want[15:8],  "cnt_b1");
        step(1'b1, 1'b0, 32'h30006, 8'h00, 1'b1, want[23:16], "cnt_b2");
        step(1'b1, 1'b0, 32'h30007, 8'h00, 1'b1, want[31:24], "cnt_b3");
        idle(3);
        step(1'b1, 1'b0, 32'h30005, 8'h00, 1'b1, want[15:8],  "cnt_b1_hold");

        // Reset while the TX FIFO holds data discards it.
        tx_ready = 1'b0;
        uart_wr(8'h61);
        uart_wr(8'h62);
        uart_wr(8'h63);
        check("pre_rst_tx_valid", tx_valid, 32'h1);
        do_reset();
        idle(1);
        check("post_rst_tx_valid", tx_valid, 32'h0);

        // Fill with back-pressure, check almost-full threshold and overflow drop,
        // then a halt command that must wait for a free slot.
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            uart_wr(i <= 6 ? 8'h41 : 8'h41 + 8'(i));
            if (i == 5) check("buf_full_at5", io_buffer_full, 32'h0);
            if (i == 6) check("buf_full_at6", io_buffer_full, 32'h1);
        end
        uart_wr(8'h5A);
        txq.push_back(8'h00);
        step(1'b1, 1'b1, 32'h30004, 8'hFF, 1'b0, 8'h00, "halt_wr_full");
        idle(1);
        check("halt_pending", halt, 32'h0);
        tx_ready = 1'b1;
        idle(12);
        check("halt_after_drain", halt, 32'h1);
        check("drain_tx_valid", tx_valid, 32'h0);
        check("drain_txq_empty", txq.size(), 32'd0);
        check("drain_buf_full", io_buffer_full, 32'h0);

        do_reset();
`ifdef MEM_IO_RX_EN
        check("rx_ready_idle", rx_ready, 32'h1);
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idle(1);
        rx_data  = 8'h32;
        idle(1);
        rx_valid = 1'b0;
        step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 8'h31, "rx_rd0");
        step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 8'h32, "rx_rd1");
        step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_rd_empty");
`else
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idle(1);
        check("rx_ready_tied", rx_ready, 32'h0);
        rx_valid = 1'b0;
        step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 8'h00, "rx_rd_off");
`endif

        // Immediate halt: 0x00 reaches TX, later writes ignored, counter frozen.
        tx_ready = 1'b0;
        halt_at  = cyc + 32'd1;
        txq.push_back(8'h00);
        step(1'b1, 1'b1, 32'h30004, 8'hAB, 1'b0, 8'h00, "halt_wr");
        check("halt_set", halt, 32'h1);
        check("halt_tx_valid", tx_valid, 32'h1);
        check("halt_tx_zero", tx_data, 32'h0);
        tx_ready = 1'b1;
        idle(1);
        step(1'b1, 1'b1, 32'h0000_0020, 8'h55, 1'b0, 8'h00, "halt_ram_wr");
        step(1'b1, 1'b1, 32'h30000, 8'h41, 1'b0, 8'h00, "halt_uart_wr");
        step(1'b1, 1'b0, 32'h0000_0020, 8'h00, 1'b1, 8'h11, "halt_ram_kept");
        check("halt_no_tx", tx_valid, 32'h0);
        idle(5);
        step(1'b1, 1'b0, 32'h30004, 8'h00, 1'b1, halt_at[7:0],  "frozen_b0");
        step(1'b1, 1'b0, 32'h30005, 8'h00, 1'b1, halt_at[15:8], "frozen_b1");
        check("halt_sticky", halt, 32'h1);
        check("final_txq_empty", txq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: RAM byte-address width (2^17 = 128 KiB).
REQ-002 Parameter TX_DEPTH_LOG, default 3: log2 of TX FIFO depth.
REQ-003 Parameter RX_DEPTH_LOG, default 2: log2 of RX FIFO depth.
REQ-004 clk_in  input  1  single clock; all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 rdy_in  input  1  bus-side enable; low freezes RAM, FIFOs, read register and halt logic.
REQ-007 mem_a  input  32  byte address from CPU; only [17:0] decoded.
REQ-008 mem_wr  input  1  1 = write, 0 = read.
REQ-009 mem_dout  input  8  write data from CPU.
REQ-010 mem_din  output  8  read data to CPU, registered.
REQ-011 io_buffer_full  output  1  TX FIFO almost full.
REQ-012 tx_valid / tx_data / tx_ready  output 1 / output 8 / input 1  UART TX stream.
REQ-013 rx_valid / rx_data / rx_ready  input 1 / input 8 / output 1  UART RX stream.
REQ-014 halt  output  1  sticky program-stop flag.

Function
REQ-015 Decode: io = (mem_a[17:16] == 2'b11); otherwise RAM index = mem_a[ADDR_WIDTH-1:0].
REQ-016 RAM write: rdy_in & mem_wr & !io -> ram[index] <= mem_dout at that edge; no read-data update.
REQ-017 Read latency is exactly 1 cycle: rdy_in & !mem_wr -> mem_din equals the selected byte after the next edge; it holds while rdy_in is low.
REQ-018 Write at 0x30000: nonzero byte pushed to TX FIFO; 0x00 ignored; a push when the FIFO is full is dropped.
REQ-019 TX FIFO: tx_valid = !empty, tx_data = head; pop on tx_valid & tx_ready (pop ignores rdy_in); simultaneous push and pop are allowed and occupancy is unchanged.
REQ-020 io_buffer_full = (occupancy >= 2^TX_DEPTH_LOG - 2): two slots of margin for CPU lag.
REQ-021 Cycle counter: 32-bit, +1 every clk_in edge while !halt, wraps at 2^32-1 to 0.
REQ-022 Read at 0x30004 snapshots the counter into a 32-bit shadow and returns byte 0; reads at 0x30005-0x30007 return shadow bytes 1-3 with no new snapshot.
REQ-023 Write at 0x30004: push 0x00 into the TX FIFO (bypasses REQ-018 filter; if full, the push waits until a slot frees), then set halt=1.
REQ-024 halt: all subsequent RAM/IO writes are ignored; reads still served; counter frozen; cleared only by reset.
REQ-025 Read at 0x30000: see Configuration. Reads of other IO addresses return 0x00; writes to them are ignored.
REQ-026 Address bits [31:18] are ignored.

Reset
REQ-027 rst_in low asynchronously sets: mem_din=0, FIFOs empty, tx_valid=0, io_buffer_full=0, counter=0, shadow=0, halt=0, rx_ready=0.
REQ-028 RAM contents are not reset; reset mid-transfer discards pending FIFO data; first edge after release acts normally.

Configuration
REQ-029 Macro MEM_IO_RX_EN defined: RX FIFO present; rx_ready = !rx_full; push on rx_valid & rx_ready; read at 0x30000 returns the head and pops it, or returns 0x00 if empty; push and pop in the same cycle are legal.
REQ-030 MEM_IO_RX_EN undefined: no RX FIFO; rx_ready tied 0; read at 0x30000 returns 0x00.

Verification
REQ-031 Write 0xA5 to 0x00010, then read 0x00010 -> mem_din = 0xA5 exactly one cycle after the read address.
REQ-032 Hold tx_ready=0; write 0x41 to 0x30000 six times (depth 8) -> io_buffer_full=1 after the 6th write; then release tx_ready -> bytes 0x41 drain in order and io_buffer_full deasserts.
REQ-033 Write 0x00 to 0x30000 -> FIFO occupancy unchanged and tx_valid stays 0.
REQ-034 After 100 cycles, read 0x30004-0x30007 on consecutive cycles -> bytes assemble to the snapshot value 100 (+/- the fixed pipeline offset), consistent across the four bytes.
REQ-035 Write any byte to 0x30004 -> 0x00 appears on tx_data and halt=1; a later write 0x55 to 0x00020 leaves the RAM byte unchanged.
REQ-036 With MEM_IO_RX_EN defined: inject 0x31, 0x32 on rx; two reads of 0x30000 -> 0x31 then 0x32; a third read -> 0x00.
